// File: rtl/fp_div_arbiter.sv
// Round-robin front end that shares one fully pipelined fpDiv core among NUM_REQ
// requesters and routes each quotient back to its issuer with a tag shift register.
module fp_div_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  DIV_LATENCY = 28,
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int IF_W        = ID_W + 6
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    issue_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [31:0]             div_a,
    output logic [31:0]             div_b,
    input  logic [31:0]             div_result,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_data,
    output logic [IF_W-1:0]         inflight,
    output logic                    busy
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [31:0]        div_a_q, div_a_d;
    logic [31:0]        div_b_q, div_b_d;
    logic [DIV_LATENCY:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [DIV_LATENCY+1];
    logic [ID_W-1:0]    tag_id_d [DIV_LATENCY+1];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [IF_W-1:0]    inflight_q, inflight_d;

    logic               found_s;
    logic [ID_W-1:0]    winner_s;
    logic               transfer_s;
    logic               retire_s;
    logic [NUM_REQ-1:0] ready_s;

    // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        found_s  = 1'b0;
        winner_s = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_valid[idx]) begin
                found_s  = 1'b1;
                winner_s = ID_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant is held off during reset and while issue is disabled (drain).
    always_comb begin
        ready_s    = '0;
        transfer_s = found_s & issue_en & aresetn;
        if (transfer_s) begin
            ready_s[winner_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Next-state: operand capture, tag pipe shift, response steering, occupancy.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_valid_d = '0;
        rsp_data_d  = div_result;
        inflight_d  = inflight_q;
        retire_s    = tag_vld_q[DIV_LATENCY-1];

        if (transfer_s) begin
            div_a_d = req_a[32*int'(winner_s) +: 32];
            div_b_d = req_b[32*int'(winner_s) +: 32];
            if (int'(winner_s) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner_s + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        tag_vld_d   = {tag_vld_q[DIV_LATENCY-1:0], transfer_s};
        tag_id_d[0] = winner_s;
        for (int s = 1; s <= DIV_LATENCY; s++) begin
            tag_id_d[s] = tag_id_q[s-1];
        end

        // Final stage lines up with the core output for that issue.
        if (tag_vld_q[DIV_LATENCY]) begin
            rsp_valid_d[tag_id_q[DIV_LATENCY]] = 1'b1;
        end else begin
            rsp_valid_d = '0;
        end

        // An op leaves the count once its quotient is on div_result.
        case ({transfer_s, retire_s})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr_q    <= '0;
            div_a_q     <= 32'h0000_0000;
            div_b_q     <= 32'h0000_0000;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 32'h0000_0000;
            inflight_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            tag_vld_q   <= tag_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            inflight_q  <= inflight_d;
        end
    end

    // Tag ids carry no reset; they are qualified by tag_vld_q.
    always_ff @(posedge aclk) begin
        for (int s = 0; s <= DIV_LATENCY; s++) begin
            tag_id_q[s] <= tag_id_d[s];
        end
    end

    assign req_ready = ready_s;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0) | (|req_valid);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a fixed-latency stand-in for the fpDiv core.
module tb_fp_div_arbiter;
    localparam int N = 4;
    localparam int L = 28;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         issue_en = 1'b0;
    logic [3:0]   req_valid = 4'b0000;
    logic [3:0]   req_ready;
    logic [127:0] req_a = 128'h0;
    logic [127:0] req_b = 128'h0;
    logic [31:0]  div_a, div_b, div_result, rsp_data;
    logic [3:0]   rsp_valid;
    logic [7:0]   inflight;
    logic         busy;

    fp_div_arbiter #(.NUM_REQ(N), .DIV_LATENCY(L)) dut (
        .aclk(aclk), .aresetn(aresetn), .issue_en(issue_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .div_a(div_a), .div_b(div_b), .div_result(div_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .busy(busy)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3fc00000 && b == 32'h3fc00000) return 32'h3f800000;
        if (a == 32'hc0600000 && b == 32'h40200000) return 32'hbfb33333;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    // Core stand-in: result valid L cycles after div_a/div_b change.
    logic [31:0] core_pipe [L];
    always @(posedge aclk) begin
        core_pipe[0] <= fdiv(div_a, div_b);
        for (int k = 1; k < L; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign div_result = core_pipe[L-1];

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] valid;
        logic       en;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs [12];

    int total = 0;
    int bad = 0;
    int stamp = 0;
    bit mon_on = 1'b0;
    logic [3:0]  exp_v [int];
    logic [31:0] exp_d [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Every cycle the response port must match the expected schedule exactly.
    always @(negedge aclk) begin
        logic [3:0] ev;
        if (mon_on) begin
            ev = exp_v.exists(cyc) ? exp_v[cyc] : 4'b0000;
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev != 4'b0000) chk("rsp_data", rsp_data, exp_d[cyc]);
        end
    end

    task automatic step(input logic [3:0] v, input logic en, input logic [3:0] er,
                        input bit spec, input string nm);
        stamp++;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = {8'(8'hA0 + i), 8'(stamp), 16'h1234};
            req_b[32*i +: 32] = {8'(8'hB0 + i), 8'(stamp), 16'h5678};
        end
        if (spec) begin
            req_a[31:0]  = 32'h3fc00000;
            req_b[31:0]  = 32'h3fc00000;
            req_a[95:64] = 32'hc0600000;
            req_b[95:64] = 32'h40200000;
        end
        req_valid = v;
        issue_en  = en;
        #1;
        chk(nm, 32'(req_ready), 32'(er));
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                exp_v[cyc+L+2] = 4'(1 << i);
                exp_d[cyc+L+2] = fdiv(req_a[32*i +: 32], req_b[32*i +: 32]);
            end
        end
        @(negedge aclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_ready");
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[2]  = '{4'b0101, 1'b1, 4'b0100};
        vecs[3]  = '{4'b0011, 1'b0, 4'b0000};
        vecs[4]  = '{4'b0011, 1'b1, 4'b0001};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000};
        vecs[6]  = '{4'b0010, 1'b1, 4'b0010};
        vecs[7]  = '{4'b1010, 1'b1, 4'b1000};
        vecs[8]  = '{4'b1010, 1'b1, 4'b0010};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000};
        vecs[10] = '{4'b0001, 1'b1, 4'b0001};
        vecs[11] = '{4'b1110, 1'b1, 4'b0010};

        repeat (2) @(negedge aclk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_div_a", div_a, 32'h0);
        chk("rst_div_b", div_b, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req_valid = 4'b1111;
        issue_en  = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        @(negedge aclk);
        aresetn   = 1'b1;
        req_valid = 4'b0000;
        mon_on    = 1'b1;

        // Single requesters with known quotients
        step(4'b0001, 1'b1, 4'b0001, 1'b1, "t1_grant");
        chk("t1_div_a", div_a, 32'h3fc00000);
        chk("t1_inflight", 32'(inflight), 32'd1);
        idle(L + 3);
        chk("t1_inflight_end", 32'(inflight), 32'd0);
        step(4'b0100, 1'b1, 4'b0100, 1'b1, "t2_grant");
        chk("t2_div_b", div_b, 32'h40200000);
        idle(L + 3);
        chk("t2_inflight_end", 32'(inflight), 32'd0);
        chk("t2_busy_end", 32'(busy), 32'd0);

        // Arbitration table, starting with rr_ptr=3
        for (int v = 0; v < 12; v++)
            step(vecs[v].valid, vecs[v].en, vecs[v].exp_ready, 1'b0, $sformatf("vec%0d", v));
        idle(L + 3);

        // Saturating back-to-back stream from rr_ptr=0
        step(4'b0100, 1'b1, 4'b0100, 1'b0, "t3_pre2");
        step(4'b1000, 1'b1, 4'b1000, 1'b0, "t3_pre3");
        idle(L + 3);
        for (int k = 0; k < 2 * L; k++) begin
            step(4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b0, "t3_rr");
            if (k == L + 5) chk("t3_inflight_sat", 32'(inflight), 32'(L));
        end
        idle(L + 3);
        chk("t3_inflight_end", 32'(inflight), 32'd0);

        // Drain with issue_en low
        step(4'b1111, 1'b1, 4'b0001, 1'b0, "t5_g0");
        step(4'b1111, 1'b1, 4'b0010, 1'b0, "t5_g1");
        step(4'b1111, 1'b1, 4'b0100, 1'b0, "t5_g2");
        repeat (4) step(4'b1111, 1'b0, 4'b0000, 1'b0, "t5_hold");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "t5_hold");
        chk("t5_inflight", 32'(inflight), 32'd3);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        idle(L + 3);
        chk("t5_busy_end", 32'(busy), 32'd0);
        chk("t5_inflight_end", 32'(inflight), 32'd0);

        // Reset mid-flight; leaves rr_ptr=3 beforehand
        step(4'b1111, 1'b1, 4'b1000, 1'b0, "t6_g3");
        step(4'b1111, 1'b1, 4'b0001, 1'b0, "t6_g0");
        step(4'b1111, 1'b1, 4'b0010, 1'b0, "t6_g1");
        step(4'b1111, 1'b1, 4'b0100, 1'b0, "t6_g2");
        step(4'b0100, 1'b1, 4'b0100, 1'b0, "t6_g2b");
        idle(4);
        aresetn   = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("t6_ready_in_rst", 32'(req_ready), 32'h0);
        @(posedge aclk);
        #1;
        exp_v.delete();
        exp_d.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        req_valid = 4'b0000;
        chk("t6_inflight_rst", 32'(inflight), 32'd0);
        idle(2 * L);
        chk("t6_inflight_quiet", 32'(inflight), 32'd0);
        step(4'b1001, 1'b1, 4'b0001, 1'b1, "t6_first_grant");
        idle(L + 3);
        chk("t6_inflight_end", 32'(inflight), 32'd0);

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
